// File: rtl/pc.sv
// Program counter for the 8-bit CPU datapath: 16-bit PC exposed as PCHI:PCLO,
// plus the PCHITMP staging register that holds the high byte of a long-jump
// target until the jump strobe arrives.
module pc (
    input  logic       clk,
    input  logic       _MR,
    input  logic       _long_jump,
    input  logic       _local_jump,
    input  logic       _pchitmp_in,
    input  logic [7:0] D,
    output logic [7:0] PCHI,
    output logic [7:0] PCLO
);

    logic [15:0] pc_q, pc_d;
    logic [7:0]  pchitmp_q, pchitmp_d;

    // PC action by priority: long jump, then local jump, then 16-bit increment.
    // The long jump reads pchitmp_q, i.e. the value held before this edge, so a
    // same-edge PCHITMP load only affects later jumps.
    always_comb begin
        pc_d = pc_q + 16'd1;
        if (!_long_jump) begin
            pc_d = {pchitmp_q, D};
        end else if (!_local_jump) begin
            pc_d = {pc_q[15:8], D};
        end
    end

    // Staging register loads independently of whatever the PC does this edge.
    always_comb begin
        pchitmp_d = pchitmp_q;
        if (!_pchitmp_in) begin
            pchitmp_d = D;
        end
    end

    // State registers; _MR clears everything immediately and holds it cleared.
    always_ff @(posedge clk or negedge _MR) begin
        if (!_MR) begin
            pc_q      <= 16'h0000;
            pchitmp_q <= 8'h00;
        end else begin
            pc_q      <= pc_d;
            pchitmp_q <= pchitmp_d;
        end
    end

    assign PCHI = pc_q[15:8];
    assign PCLO = pc_q[7:0];

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: a behavioural model tracks the expected PC and
// staging byte; one process compares every cycle, and directed steps pin the
// model with hand-computed literal values.
module tb_pc;

    logic       clk;
    logic       mr_n;
    logic       long_n;
    logic       local_n;
    logic       tmp_n;
    logic [7:0] d;
    logic [7:0] pchi;
    logic [7:0] pclo;

    int checks = 0;
    int passes = 0;
    bit chk_en = 0;

    logic [15:0] pc_m;
    logic [7:0]  tmp_m;

    pc dut (
        .clk         (clk),
        ._MR         (mr_n),
        ._long_jump  (long_n),
        ._local_jump (local_n),
        ._pchitmp_in (tmp_n),
        .D           (d),
        .PCHI        (pchi),
        .PCLO        (pclo)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    // Behavioural model: what the PC must be, straight from the operating rules.
    always @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            pc_m  <= 16'h0000;
            tmp_m <= 8'h00;
        end else begin
            if (!long_n)       pc_m <= {tmp_m, d};
            else if (!local_n) pc_m <= {pc_m[15:8], d};
            else               pc_m <= 16'((32'(pc_m) + 1) % 65536);
            if (!tmp_n)        tmp_m <= d;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({pchi, pclo} === pc_m) passes++;
            else $display("FAIL model_cmp t=%0t got %h%h expected %h", $time, pchi, pclo, pc_m);
        end
    end

    task automatic lit(input string name, input logic [15:0] exp);
        checks++;
        if ({pchi, pclo} === exp) passes++;
        else $display("FAIL %s got %h%h expected %h", name, pchi, pclo, exp);
    endtask

    // Drive controls, then take one rising edge and settle just after it.
    task automatic edge_with(input logic ln, input logic lc, input logic tn, input logic [7:0] dv);
        long_n = ln; local_n = lc; tmp_n = tn; d = dv;
        @(posedge clk); #5;
        long_n = 1'b1; local_n = 1'b1; tmp_n = 1'b1;
    endtask

    initial begin
        mr_n = 1'b0; long_n = 1'b1; local_n = 1'b1; tmp_n = 1'b1; d = 8'h00;
        #10;
        lit("reset_async", 16'h0000);
        @(posedge clk); #5;
        lit("reset_clocked", 16'h0000);
        mr_n = 1'b1; #1;
        lit("release_no_edge", 16'h0000);
        chk_en = 1;

        edge_with(1, 1, 1, 8'h00); lit("count1", 16'h0001);
        edge_with(1, 1, 1, 8'h00); lit("count2", 16'h0002);
        edge_with(1, 1, 0, 8'hFF); lit("tmp_load_inc", 16'h0003);
        @(negedge clk); #1;        lit("falling_edge_hold", 16'h0003);
        edge_with(1, 1, 1, 8'h00); lit("count4", 16'h0004);
        edge_with(0, 1, 1, 8'hAA); lit("long_jump", 16'hFFAA);
        edge_with(1, 0, 1, 8'hFE); lit("local_jump", 16'hFFFE);
        edge_with(1, 1, 1, 8'h00); lit("pre_wrap", 16'hFFFF);
        edge_with(1, 1, 1, 8'h00); lit("wrap", 16'h0000);
        edge_with(1, 1, 1, 8'h00);
        edge_with(1, 1, 1, 8'h00); lit("post_wrap", 16'h0002);

        // Asynchronous reset between edges, held low while strobes toggle.
        #10; mr_n = 1'b0; #1;
        lit("reset_mid_count", 16'h0000);
        for (int i = 0; i < 3; i++) begin
            edge_with(0, 0, 0, 8'h55);
            lit("reset_hold", 16'h0000);
        end
        #10; mr_n = 1'b1; #1;
        lit("release_hold", 16'h0000);
        edge_with(1, 1, 1, 8'h00); lit("first_after_release", 16'h0001);
        edge_with(0, 1, 1, 8'h34); lit("tmp_cleared_by_reset", 16'h0034);

        // Same-edge load and long jump uses the old staging value.
        edge_with(1, 1, 0, 8'h77); lit("tmp77_inc", 16'h0035);
        edge_with(0, 1, 0, 8'h10); lit("same_edge_jump", 16'h7710);
        edge_with(0, 1, 1, 8'h20); lit("jump_new_tmp", 16'h1020);
        edge_with(0, 0, 1, 8'h40); lit("long_over_local", 16'h1040);
        edge_with(1, 0, 1, 8'hFF); lit("local_ff", 16'h10FF);
        edge_with(1, 1, 1, 8'h00); lit("carry_into_hi", 16'h1100);

        // Mixed random strobes, model-checked each cycle.
        for (int i = 0; i < 2000; i++) begin
            edge_with(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 2) == 0), 8'($urandom));
        end

        // Long idle run from reset: PC equals edge count modulo 65536, one wrap.
        #10; mr_n = 1'b0; #10; mr_n = 1'b1;
        for (int i = 1; i <= 65600; i++) begin
            @(posedge clk); #5;
            if (i == 65535) lit("full_ffff", 16'hFFFF);
            if (i == 65536) lit("full_wrap", 16'h0000);
            if (i == 65600) lit("full_end", 16'h0040);
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
